// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline definitions: machine widths, the ID/EX
//                bundle layout with its field offsets, and pack/unpack helpers.
//                Stage wrappers and pipe_stage_skid use these so that every
//                stage agrees on the bit layout of the flat payload bus.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    // ID/EX bundle: six XLEN words plus three register addresses.
    localparam int ID_EX_W     = 6 * XLEN + 3 * REG_ADDR_W;   // 207
    // Bus width actually carried by the stage register (rounded up).
    localparam int ID_EX_PAD_W = 224;

    // Field offsets (LSB positions) inside the ID/EX bundle, low to high.
    localparam int ID_EX_RD_LSB     = 0;
    localparam int ID_EX_RS2_LSB    = ID_EX_RD_LSB     + REG_ADDR_W;
    localparam int ID_EX_RS1_LSB    = ID_EX_RS2_LSB    + REG_ADDR_W;
    localparam int ID_EX_IMM_LSB    = ID_EX_RS1_LSB    + REG_ADDR_W;
    localparam int ID_EX_RD2_LSB    = ID_EX_IMM_LSB    + XLEN;
    localparam int ID_EX_RD1_LSB    = ID_EX_RD2_LSB    + XLEN;
    localparam int ID_EX_PCP4_LSB   = ID_EX_RD1_LSB    + XLEN;
    localparam int ID_EX_PC_LSB     = ID_EX_PCP4_LSB   + XLEN;
    localparam int ID_EX_INSTR_LSB  = ID_EX_PC_LSB     + XLEN;

    // Packed struct declared MSB first so its layout matches the offsets above.
    typedef struct packed {
        logic [XLEN-1:0]       instr;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       pc_plus4;
        logic [XLEN-1:0]       rd1;
        logic [XLEN-1:0]       rd2;
        logic [XLEN-1:0]       imm_ext;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
    } id_ex_t;

    // Place the bundle in the low bits of the padded bus; pad bits are zero.
    function automatic logic [ID_EX_PAD_W-1:0] pack_id_ex(input id_ex_t f);
        return {{(ID_EX_PAD_W - ID_EX_W){1'b0}}, f};
    endfunction

    // Callers pass bus[ID_EX_W-1:0]; the pad bits carry nothing.
    function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] bus);
        return id_ex_t'(bus);
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_slot
//  Description : One pipeline slot: a valid bit plus a DATA_W data register.
//                clear has priority over load. With CLEAR_DATA=1 a clear also
//                zeros the data; with 0 only the valid bit drops.
//  Ports       : clk   - rising-edge clock
//                reset - asynchronous active-low reset
//                load  - capture d, set valid
//                clear - drop valid (and zero data when CLEAR_DATA=1)
//                d     - data to capture
//                valid - slot holds a payload
//                q     - held payload
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_slot #(
    parameter int DATA_W     = 32,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d,
    output logic              valid,
    output logic [DATA_W-1:0] q
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (clear) begin
            r_valid <= 1'b0;
            if (CLEAR_DATA) begin
                r_data <= '0;
            end
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= d;
        end
    end

    assign valid = r_valid;
    assign q     = r_data;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_skid
//  Description : Inter-stage pipeline register with ready/valid handshake and
//                a 2-entry skid buffer (main + skid). in_ready depends only on
//                the skid valid register, so downstream stalls never form a
//                combinational path to upstream. Synchronous flush squashes all
//                held entries and this cycle's input; flush_cnt counts the
//                squashed valid entries and saturates.
//  Ports       : clk, reset (async active-low), flush,
//                in_valid / in_ready / in_data   - upstream side
//                out_valid / out_ready / out_data - downstream side
//                occupancy - entries held (0..2)
//                flush_cnt - saturating count of flushed entries
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W     = ID_EX_PAD_W,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);

    // State is {main_valid, skid_valid}: 00 EMPTY, 10 ONE, 11 FULL.
    // 01 (skid without main) must never occur.
    localparam logic [1:0] c_ST_SKID_ONLY = 2'b01;

    logic              w_main_valid;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_main_q;
    logic [DATA_W-1:0] w_skid_q;
    logic              w_acc;
    logic              w_pop;
    logic              w_main_load;
    logic              w_main_clr;
    logic [DATA_W-1:0] w_main_d;
    logic              w_skid_load;
    logic              w_skid_clr;
    logic [1:0]        w_state;
    logic [CNT_W:0]    w_cnt_sum;
    logic [CNT_W-1:0]  r_flush_cnt;

    assign w_state = {w_main_valid, w_skid_valid};

    assign in_ready = ~w_skid_valid;
    assign w_acc    = in_valid & in_ready & ~flush;
    assign w_pop    = w_main_valid & out_ready & ~flush;

    // Main refills from skid first so ordering holds; otherwise from input.
    // When main is empty the skid is empty too, so the mux picks in_data.
    assign w_main_d    = w_skid_valid ? w_skid_q : in_data;
    assign w_main_load = (~w_main_valid & w_acc) | (w_pop & (w_skid_valid | w_acc));
    assign w_main_clr  = flush | (w_pop & ~w_skid_valid & ~w_acc);

    // Skid only fills when main is held this cycle; it drains whenever main pops.
    assign w_skid_load = w_acc & w_main_valid & ~w_pop;
    assign w_skid_clr  = flush | (w_pop & w_skid_valid);

    pipe_slot #(
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .load  (w_main_load),
        .clear (w_main_clr),
        .d     (w_main_d),
        .valid (w_main_valid),
        .q     (w_main_q)
    );

    pipe_slot #(
        .DATA_W     (DATA_W),
        .CLEAR_DATA (CLEAR_DATA)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (w_skid_load),
        .clear (w_skid_clr),
        .d     (in_data),
        .valid (w_skid_valid),
        .q     (w_skid_q)
    );

    assign out_valid = w_main_valid;
    assign out_data  = w_main_q;
    assign occupancy = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

    // One extra bit catches the carry that signals saturation.
    assign w_cnt_sum = {1'b0, r_flush_cnt} + (CNT_W+1)'(occupancy);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flush_cnt <= '0;
        end else if (flush) begin
            r_flush_cnt <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
        end
    end

    assign flush_cnt = r_flush_cnt;

    a_no_skid_without_main : assert property (
        @(posedge clk) disable iff (!reset) (w_state != c_ST_SKID_ONLY)
    );

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_skid
//  Description : Directed and randomised self-checking bench for
//                pipe_stage_skid (DATA_W=32, CLEAR_DATA=1, CNT_W=2).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int DW = 32;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [CW-1:0] flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_skid #(
        .DATA_W     (DW),
        .CLEAR_DATA (1'b1),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b0;
        #2;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        n_checks++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        n_checks++; if (flush_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_flush_cnt got %0d want 0", flush_cnt); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            in_data = DW'(i);
            step();
            n_checks++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin n_fail++; $display("FAIL stream_data[%0d] got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, DW'(i)); end
            n_checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_occ[%0d] got occ=%0d rdy=%0b want occ=1 rdy=1", i, occupancy, in_ready); end
        end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain got v=%0b d=%h occ=%0d want v=0 d=0 occ=0", out_valid, out_data, occupancy); end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        n_checks++; if (out_data !== 32'hA || occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_a got d=%h occ=%0d rdy=%0b want d=a occ=1 rdy=1", out_data, occupancy, in_ready); end
        in_data = 32'hB;
        step();
        n_checks++; if (out_data !== 32'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_b_skid got d=%h occ=%0d rdy=%0b want d=a occ=2 rdy=0", out_data, occupancy, in_ready); end
        in_data = 32'hC;
        step();
        n_checks++; if (out_data !== 32'hA || occupancy !== 2'd2 || in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_c_held got d=%h occ=%0d rdy=%0b want d=a occ=2 rdy=0", out_data, occupancy, in_ready); end
        out_ready = 1'b1;
        step();
        n_checks++; if (out_data !== 32'hB || occupancy !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_out_b got d=%h occ=%0d rdy=%0b want d=b occ=1 rdy=1", out_data, occupancy, in_ready); end
        step();
        n_checks++; if (out_data !== 32'hC || occupancy !== 2'd1) begin n_fail++; $display("FAIL bp_out_c got d=%h occ=%0d want d=c occ=1", out_data, occupancy); end
        in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_empty got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
        idle_inputs();
    endtask

    task automatic fill_full(input logic [DW-1:0] a, input logic [DW-1:0] b);
        out_ready = 1'b0; in_valid = 1'b1; in_data = a;
        step();
        in_data = b;
        step();
    endtask

    task automatic test_flush_full();
        fill_full(32'h11, 32'h22);
        n_checks++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDD; out_ready = 1'b1;
        step();
        n_checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'd0) begin n_fail++; $display("FAIL flush_clear got occ=%0d v=%0b d=%h want occ=0 v=0 d=0", occupancy, out_valid, out_data); end
        n_checks++; if (flush_cnt !== 2'd2 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_cnt got cnt=%0d rdy=%0b want cnt=2 rdy=1", flush_cnt, in_ready); end
        flush = 1'b0; in_valid = 1'b0;
        step();
        n_checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_drop_d got v=%0b occ=%0d want v=0 occ=0", out_valid, occupancy); end
        idle_inputs();
    endtask

    task automatic test_saturation();
        logic [CW-1:0] exp_cnt [4];
        exp_cnt[0] = 2'd2; exp_cnt[1] = 2'd3; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            fill_full(DW'(k + 100), DW'(k + 200));
            flush = 1'b1; in_valid = 1'b0;
            step();
            flush = 1'b0;
            n_checks++; if (flush_cnt !== exp_cnt[k]) begin n_fail++; $display("FAIL sat_cnt[%0d] got %0d want %0d", k, flush_cnt, exp_cnt[k]); end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        apply_reset();
        fill_full(32'h33, 32'h44);
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_data !== 32'd0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL areset_clear got v=%0b d=%h occ=%0d want v=0 d=0 occ=0", out_valid, out_data, occupancy); end
        n_checks++; if (in_ready !== 1'b1 || flush_cnt !== 2'd0) begin n_fail++; $display("FAIL areset_ready got rdy=%0b cnt=%0d want rdy=1 cnt=0", in_ready, flush_cnt); end
        #1;
        reset = 1'b1;
        in_valid = 1'b1; in_data = 32'h55;
        step();
        n_checks++; if (out_valid !== 1'b1 || out_data !== 32'h55 || occupancy !== 2'd1) begin n_fail++; $display("FAIL areset_accept got v=%0b d=%h occ=%0d want v=1 d=55 occ=1", out_valid, out_data, occupancy); end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [DW-1:0] mq[$];
        logic [CW:0]   msum;
        logic [CW-1:0] mcnt;
        logic          m_rdy, m_acc, m_pop;
        int            npush, npop;
        npush = 0; npop = 0; mcnt = '0;
        apply_reset();
        for (int c = 0; c < 10000; c++) begin
            // Compare current outputs with the queue model.
            m_rdy = (mq.size() < 2);
            n_checks++; if (in_ready !== m_rdy || out_valid !== (mq.size() > 0) || occupancy !== 2'(mq.size())) begin n_fail++; $display("FAIL rnd_ctrl[%0d] got rdy=%0b v=%0b occ=%0d want rdy=%0b occ=%0d", c, in_ready, out_valid, occupancy, m_rdy, mq.size()); end
            n_checks++; if (out_data !== ((mq.size() > 0) ? mq[0] : '0)) begin n_fail++; $display("FAIL rnd_data[%0d] got %h want %h", c, out_data, (mq.size() > 0) ? mq[0] : '0); end
            n_checks++; if (flush_cnt !== mcnt) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", c, flush_cnt, mcnt); end
            // New stimulus.
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            in_data   = $urandom;
            m_acc = in_valid && m_rdy && !flush;
            m_pop = (mq.size() > 0) && out_ready && !flush;
            if (flush) begin
                msum = {1'b0, mcnt} + (CW+1)'(mq.size());
                mcnt = msum[CW] ? '1 : msum[CW-1:0];
                mq.delete();
            end else begin
                if (m_pop) begin void'(mq.pop_front()); npop++; end
                if (m_acc) begin mq.push_back(in_data); npush++; end
            end
            step();
        end
        n_checks++; if (npush == 0 || npop == 0) begin n_fail++; $display("FAIL rnd_activity got push=%0d pop=%0d want both nonzero", npush, npop); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_saturation();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pipe_stage_skid
`default_nettype wire
